// File: rtl/cdc_edge_async_reset_byte_packer.sv
// Byte-to-word packer: LANES bytes little-endian into one word with keep/last; optional out_parity via CDC_PACKER_PARITY_EN.
// Latency: word valid the cycle after its final byte is accepted; 1 byte/cycle sustained.
// Backpressure: in_ready = out_ready while a word is held, so a transfer and a new lane-0 byte share a cycle.
module cdc_edge_async_reset_byte_packer #(
    parameter int DATA_W = 8,
    parameter int LANES  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    async_rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W*LANES-1:0] out_data,
    output logic [LANES-1:0]        out_keep,
    output logic                    out_last,
`ifdef CDC_PACKER_PARITY_EN
    output logic                    out_parity,
`endif
    output logic [CNT_W-1:0]        word_count
);

    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    typedef enum logic {FILL, HOLD} state_t;

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [DATA_W*LANES-1:0]   data_q, data_d;
    logic [LANES-1:0]          keep_q, keep_d;
    logic                      last_q, last_d;
    logic [CNT_W-1:0]          count_q, count_d;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        data_d    = data_q;
        keep_d    = keep_q;
        last_d    = last_q;
        count_d   = count_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            FILL: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    data_d[idx_q*DATA_W +: DATA_W] = in_data;
                    keep_d[idx_q]                  = 1'b1;
                    if (idx_q == LAST_IDX || in_last) begin
                        state_d = HOLD;
                        idx_d   = '0;
                        last_d  = in_last;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                // Combinational ready: a byte is only taken when the held word leaves.
                in_ready  = out_ready;
                if (out_ready) begin
                    if (count_q != {CNT_W{1'b1}}) begin
                        count_d = count_q + CNT_W'(1);
                    end
                    if (in_valid) begin
                        data_d               = '0;
                        data_d[DATA_W-1:0]   = in_data;
                        keep_d               = LANES'(1);
                        last_d               = in_last;
                        if (in_last) begin
                            state_d = HOLD;
                            idx_d   = '0;
                        end else begin
                            state_d = FILL;
                            idx_d   = IDX_W'(1);
                        end
                    end else begin
                        state_d = FILL;
                        data_d  = '0;
                        keep_d  = '0;
                        last_d  = 1'b0;
                        idx_d   = '0;
                    end
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            state_q <= FILL;
            idx_q   <= '0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
            count_q <= count_d;
        end
    end

`ifdef CDC_PACKER_PARITY_EN
    logic parity_q, parity_d;

    // Tracks data_q exactly, so it is stable for as long as the word is held.
    always_comb begin
        parity_d = ^data_d;
    end

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign out_parity = parity_q;
`endif

    assign out_data   = data_q;
    assign out_keep   = keep_q;
    assign out_last   = last_q;
    assign word_count = count_q;

endmodule
